edid_fetch_ctl: RTL
===================

EDID_FETCH_CTL -- requirements
Module: edid_fetch_ctl

Interface
REQ-001 Parameters SHALL be: DEV_ADDR, default 7'h50, DDC slave address; MAX_RETRY, default 3, attempts per block; TIMEOUT_CYC, default 25000, max cycles waiting for a byte (1 ms at 25 MHz).
REQ-002 Ports SHALL be: gclk input 1, system clock; rst input 1, reset, synchronous, active-high.
REQ-003 edid_init input 1, start pulse; monitor_hpd input 1, monitor present (level).
REQ-004 edid_read_ok output 1, level, EDID valid; edid_fail output 1, level, fetch failed; busy output 1, fetch in progress; ext_present output 1, block 1 fetched.
REQ-005 i2c_req output 1, one-cycle byte-read request; i2c_dev output 7, equals DEV_ADDR; i2c_offset output 8, EDID word offset.
REQ-006 i2c_ack input 1, one-cycle byte done; i2c_nack input 1, one-cycle bus error; i2c_rdata input 8, valid with i2c_ack.
REQ-007 buf_we output 1, buffer write strobe; buf_addr output 8, byte address 0..255; buf_wdata output 8, byte data.

Function
REQ-008 States SHALL be IDLE, REQ, WAIT, WRITE, CHECK, DONE, FAIL.
REQ-009 IDLE: edid_init=1 with monitor_hpd=1 SHALL clear ok/fail/ext_present, set block=0, byte=0, retry=0, csum=0, go REQ; edid_init with monitor_hpd=0 is ignored.
REQ-010 REQ: i2c_req=1 for exactly one cycle with i2c_offset={block,byte[6:0]}; next state WAIT; timeout counter loaded with TIMEOUT_CYC.
REQ-011 WAIT: i2c_nack, or counter reaching 0, SHALL be a byte failure; i2c_ack SHALL latch i2c_rdata and go WRITE; ack and nack in the same cycle SHALL count as nack.
REQ-012 WRITE (ack cycle T, WRITE at T+1): buf_we=1, buf_addr={block,byte[6:0]}, buf_wdata=latched byte; csum <= csum+byte mod 256; byte 126 of block 0 latched as ext count.
REQ-013 WRITE: byte index 0..7 of block 0 SHALL be compared to 00 FF FF FF FF FF FF 00; any mismatch sets a header-error flag.
REQ-014 WRITE: byte<127 SHALL increment byte and go REQ; byte=127 SHALL go CHECK (T+2).
REQ-015 CHECK: block passes iff csum==0 and (block=1 or header-error=0); failure is a block failure.
REQ-016 CHECK pass, block 0, ext count≠0: block=1, byte=0, csum=0, retry=0, go REQ; ext count>1 SHALL still fetch only block 1.
REQ-017 CHECK pass otherwise: go DONE; edid_read_ok=1 at T+3; ext_present=1 iff block 1 fetched.
REQ-018 Byte or block failure: retry+1; if retry+1<MAX_RETRY restart current block from byte 0 with csum and header flag cleared; else go FAIL, edid_fail=1 next cycle.
REQ-019 DONE/FAIL: outputs hold; edid_init with monitor_hpd=1 restarts as REQ-009; monitor_hpd=0 clears edid_read_ok and ext_present, goes IDLE; edid_fail holds until next edid_init.
REQ-020 monitor_hpd=0 in any of REQ/WAIT/WRITE/CHECK SHALL abort to IDLE next cycle: no buf_we, ok=0, fail=0; a late i2c_ack is ignored.
REQ-021 edid_init while busy SHALL be ignored.
REQ-022 busy=1 in REQ, WAIT, WRITE, CHECK; i2c_req and buf_we never asserted in the same cycle.
REQ-023 Block 0 writes addresses 0..127 only; block 1 writes 128..255 only; address never wraps.

Reset
REQ-024 rst=1 at a gclk edge SHALL force IDLE; i2c_req, buf_we, edid_read_ok, edid_fail, busy, ext_present = 0; buf_addr, buf_wdata, i2c_offset, counters, csum = 0; i2c_dev = DEV_ADDR.
REQ-025 rst mid-fetch SHALL abandon the fetch without further buf_we; the next start needs a fresh edid_init.

Verification
REQ-026 Valid 128-byte EDID, byte126=0, csum 0, ack 5 cycles after each req -> 128 buf_we at addresses 0..127; edid_read_ok=1 3 cycles after the final ack; ext_present=0.
REQ-027 Byte126=1, valid block 1 -> 256 writes, 128..255 for block 1; ok=1; ext_present=1.
REQ-028 Nack at offset 40 on first attempt -> block restarts at offset 0; success; 168 total writes; ok=1.
REQ-029 Byte 3 = 0xFE on every attempt, MAX_RETRY=3 -> three full block-0 passes; edid_fail=1; ok=0; busy=0.
REQ-030 No ack, TIMEOUT_CYC=16 -> retry after 16 cycles; fail after 3 attempts.
REQ-031 monitor_hpd drops at offset 60 -> IDLE next cycle; no further req or we; a late ack is ignored; edid_init with hpd=1 restarts at offset 0.

Source files
------------

// File: rtl/edid_fetch_ctl.sv
// edid_fetch_ctl: fetches EDID block 0 (and block 1 when present) over DDC into a 256-byte buffer
module edid_fetch_ctl #(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         MAX_RETRY   = 3,
    parameter int         TIMEOUT_CYC = 25000
) (
    input  logic       gclk,
    input  logic       rst,
    input  logic       edid_init,
    input  logic       monitor_hpd,
    output logic       edid_read_ok,
    output logic       edid_fail,
    output logic       busy,
    output logic       ext_present,
    output logic       i2c_req,
    output logic [6:0] i2c_dev,
    output logic [7:0] i2c_offset,
    input  logic       i2c_ack,
    input  logic       i2c_nack,
    input  logic [7:0] i2c_rdata,
    output logic       buf_we,
    output logic [7:0] buf_addr,
    output logic [7:0] buf_wdata
);
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAIL  = 3'd6;
    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam int RW = $clog2(MAX_RETRY + 1);
    logic [2:0]    state;
    logic          blk;
    logic [6:0]    idx;
    logic [RW-1:0] retry;
    logic [7:0]    csum;
    logic [7:0]    ext_cnt;
    logic [7:0]    data;
    logic          hdr_err;
    logic [CW-1:0] tmo;
    logic          start;
    logic          last_try;
    logic          blk_pass;
    logic          fail_now;
    logic [7:0]    hdr_exp;
    assign start      = edid_init && monitor_hpd;
    assign busy       = state == S_REQ || state == S_WAIT || state == S_WRITE || state == S_CHECK;
    assign i2c_req    = state == S_REQ;
    assign buf_we     = state == S_WRITE;
    assign i2c_dev    = DEV_ADDR;
    assign i2c_offset = {blk, idx};
    assign buf_addr   = {blk, idx};
    assign buf_wdata  = data;
    assign hdr_exp    = (idx == 7'd0 || idx == 7'd7) ? 8'h00 : 8'hFF;
    assign last_try   = int'(retry) + 1 >= MAX_RETRY;
    assign blk_pass   = csum == 8'd0 && (blk || !hdr_err);
    // A byte fails on nack (which beats a simultaneous ack) or when the wait budget runs out without an ack
    assign fail_now   = (state == S_WAIT && (i2c_nack || (!i2c_ack && tmo <= CW'(1))))
                     || (state == S_CHECK && !blk_pass);
    // Fetch sequencer: hot-plug loss aborts first, then start, then retry handling, then normal flow
    always_ff @(posedge gclk) begin
        if (rst) begin
            state        <= S_IDLE;
            edid_read_ok <= 1'b0;
            edid_fail    <= 1'b0;
            ext_present  <= 1'b0;
            blk          <= 1'b0;
            idx          <= 7'd0;
            retry        <= '0;
            csum         <= 8'd0;
            ext_cnt      <= 8'd0;
            data         <= 8'd0;
            hdr_err      <= 1'b0;
            tmo          <= '0;
        end else if (busy && !monitor_hpd) begin
            state        <= S_IDLE;
            edid_read_ok <= 1'b0;
            edid_fail    <= 1'b0;
        end else if (!busy && start) begin
            state        <= S_REQ;
            edid_read_ok <= 1'b0;
            edid_fail    <= 1'b0;
            ext_present  <= 1'b0;
            blk          <= 1'b0;
            idx          <= 7'd0;
            retry        <= '0;
            csum         <= 8'd0;
            hdr_err      <= 1'b0;
        end else if (fail_now) begin
            if (last_try) begin
                state     <= S_FAIL;
                edid_fail <= 1'b1;
            end else begin
                state   <= S_REQ;
                retry   <= retry + 1'b1;
                idx     <= 7'd0;
                csum    <= 8'd0;
                hdr_err <= 1'b0;
            end
        end else begin
            case (state)
                S_DONE, S_FAIL: begin
                    if (!monitor_hpd) begin
                        state        <= S_IDLE;
                        edid_read_ok <= 1'b0;
                        ext_present  <= 1'b0;
                    end
                end
                S_REQ: begin
                    tmo   <= CW'(TIMEOUT_CYC);
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i2c_ack) begin
                        data  <= i2c_rdata;
                        state <= S_WRITE;
                    end else begin
                        tmo <= tmo - 1'b1;
                    end
                end
                S_WRITE: begin
                    csum <= csum + data;
                    if (!blk && idx == 7'd126) ext_cnt <= data;
                    if (!blk && idx < 7'd8 && data != hdr_exp) hdr_err <= 1'b1;
                    if (idx != 7'h7F) idx <= idx + 7'd1;
                    state <= idx == 7'h7F ? S_CHECK : S_REQ;
                end
                S_CHECK: begin
                    if (!blk && ext_cnt != 8'd0) begin
                        state <= S_REQ;
                        blk   <= 1'b1;
                        idx   <= 7'd0;
                        csum  <= 8'd0;
                        retry <= '0;
                    end else begin
                        state        <= S_DONE;
                        edid_read_ok <= 1'b1;
                        ext_present  <= blk;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
